// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared widths and line types for the data cache
package data_cache_pkg;
  localparam int DC_ADDR_WIDTH = 26;
  localparam int DC_DATA_WIDTH = 32;
  localparam int DC_INDEX_BITS = 4;
  localparam int DC_TAG_WIDTH  = DC_ADDR_WIDTH - DC_INDEX_BITS;
  localparam int DC_LINES      = 1 << DC_INDEX_BITS;

  typedef logic [DC_TAG_WIDTH-1:0] tag_t;

  typedef struct packed {
    logic                     valid;
    tag_t                     tag;
    logic [DC_DATA_WIDTH-1:0] word;
  } cache_line_t;
endpackage

// File: rtl/data_cache_line_array.sv
// rtl/data_cache_line_array.sv - one-word line storage, sync write, async read
// Only the valid bits are reset; tag and word contents are meaningless until filled.
module data_cache_line_array
  import data_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
  parameter int DATA_WIDTH = DC_DATA_WIDTH,
  parameter int INDEX_BITS = DC_INDEX_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [INDEX_BITS-1:0]          index,
  input  logic [ADDR_WIDTH-INDEX_BITS-1:0] wr_tag,
  input  logic [DATA_WIDTH-1:0]          wr_word,
  output logic                           rd_valid,
  output logic [ADDR_WIDTH-INDEX_BITS-1:0] rd_tag,
  output logic [DATA_WIDTH-1:0]          rd_word
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [TAG_W-1:0]      tag_d  [LINES];
  logic [DATA_WIDTH-1:0] word_q [LINES];
  logic [DATA_WIDTH-1:0] word_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    word_d  = word_q;
    if (wr_en) begin
      valid_d[index] = 1'b1;
      tag_d[index]   = wr_tag;
      word_d[index]  = wr_word;
    end
  end

  // Reset only needs to kill valid; a fill on the reset edge is thereby dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    word_q <= word_d;
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_word  = word_q[index];
endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-allocate word cache on a shared tri-state bus
// Optional hit/miss counters are enabled by defining DATA_CACHE_STATS_EN.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
  parameter int DATA_WIDTH = DC_DATA_WIDTH,
  parameter int INDEX_BITS = DC_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  we,
  input  logic                  oe,
`ifdef DATA_CACHE_STATS_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  output logic                  found
);
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_W-1:0]      tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  fill_en;
  logic                  read_req;
  logic                  drive_en;

  assign index = addr[INDEX_BITS-1:0];
  assign tag   = addr[ADDR_WIDTH-1:INDEX_BITS];

  assign fill_en  = cs & we;
  assign read_req = cs & oe & ~we;

  data_cache_line_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_lines (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (fill_en),
    .index    (index),
    .wr_tag   (tag),
    .wr_word  (data),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word)
  );

  // valid gates the compare so stale or uninitialised tags can never hit.
  assign found    = cs & rd_valid & (rd_tag == tag);
  assign drive_en = read_req & found;
  assign data     = drive_en ? rd_word : 'z;

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (read_req) begin
      if (found) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed and randomized checks of data_cache against an address-owner model
module tb_data_cache;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        we;
  logic        oe;
  logic [25:0] addr;
  logic        found;
  logic        drv_en;
  logic [31:0] drv_val;
  wire  [31:0] data_bus;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  assign data_bus = drv_en ? drv_val : 'z;

  always #5 clk = ~clk;

  data_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .addr       (addr),
    .data       (data_bus),
    .we         (we),
    .oe         (oe),
`ifdef DATA_CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .found      (found)
  );

  // Each line is modelled as "which full address owns it, and with what word".
  logic [25:0] owner   [int];
  logic [31:0] content [int];
  longint      m_hits;
  longint      m_misses;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [25:0] a);
    int idx = int'(a % 26'd16);
    return owner.exists(idx) && owner[idx] == a;
  endfunction

  task automatic do_op(input logic c, input logic w, input logic o, input logic r,
                       input logic [25:0] a, input logic [31:0] d);
    bit exp_found;
    bit released;
    int idx;
    @(negedge clk);
    rst_n = r; cs = c; we = w; oe = o; addr = a;
    drv_en = w; drv_val = d;
    #1;
    exp_found = c && model_hit(a);
    idx = int'(a % 26'd16);
    check_eq("found", {31'd0, found}, {31'd0, exp_found});
    if (c && o && !w && exp_found) begin
      check_eq("read_data", data_bus, content[idx]);
    end else if (w) begin
      check_eq("bus_no_contention", data_bus, d);
    end else begin
      released = (data_bus === 32'hzzzz_zzzz) || (data_bus == 32'h0);
      check_eq("bus_released", {31'd0, released}, 32'd1);
    end
`ifdef DATA_CACHE_STATS_EN
    check_eq("hit_count", hit_count, 32'(m_hits));
    check_eq("miss_count", miss_count, 32'(m_misses));
`endif
    @(posedge clk);
    if (!r) begin
      owner.delete();
      content.delete();
      m_hits = 0;
      m_misses = 0;
    end else begin
      if (c && w) begin
        owner[idx]   = a;
        content[idx] = d;
      end
      if (c && o && !w) begin
        if (exp_found) m_hits = (m_hits == 64'hFFFF_FFFF) ? m_hits : m_hits + 1;
        else           m_misses = (m_misses == 64'hFFFF_FFFF) ? m_misses : m_misses + 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0; addr = '0;
    drv_en = 1'b0; drv_val = '0;
    m_hits = 0; m_misses = 0;

    do_op(0, 0, 0, 0, 26'h0, 32'h0);
    do_op(0, 0, 0, 0, 26'h0, 32'h0);
    do_op(1, 0, 1, 1, 26'h100, 32'h0);

    do_op(1, 1, 0, 1, 26'h100, 32'h1000011E);
    do_op(1, 0, 1, 1, 26'h100, 32'h0);

    do_op(1, 1, 0, 1, 26'h100, 32'hA);
    do_op(1, 1, 0, 1, 26'h110, 32'hB);
    do_op(1, 0, 1, 1, 26'h100, 32'h0);
    do_op(1, 0, 1, 1, 26'h110, 32'h0);

    do_op(1, 1, 0, 1, 26'h120, 32'h78000001);
    do_op(1, 1, 0, 1, 26'h120, 32'h5);
    do_op(1, 0, 1, 1, 26'h120, 32'h0);

    do_op(1, 1, 1, 1, 26'h120, 32'h77);
    do_op(1, 0, 1, 1, 26'h120, 32'h0);
    do_op(0, 0, 1, 1, 26'h120, 32'h0);
    do_op(0, 1, 0, 1, 26'h120, 32'h99);
    do_op(1, 0, 1, 1, 26'h120, 32'h0);

    do_op(1, 1, 0, 0, 26'h104, 32'h44);
    do_op(1, 0, 1, 1, 26'h104, 32'h0);
    do_op(1, 0, 1, 1, 26'h120, 32'h0);

    do_op(0, 0, 0, 0, 26'h0, 32'h0);
    do_op(1, 1, 0, 1, 26'h130, 32'hC0DE_0001);
    do_op(1, 0, 1, 1, 26'h130, 32'h0);
    do_op(1, 0, 1, 1, 26'h130, 32'h0);
    do_op(1, 0, 1, 1, 26'h130, 32'h0);
    do_op(1, 0, 1, 1, 26'h140, 32'h0);
    do_op(1, 0, 1, 1, 26'h131, 32'h0);
`ifdef DATA_CACHE_STATS_EN
    @(negedge clk);
    check_eq("hit_count_3", hit_count, 32'd3);
    check_eq("miss_count_2", miss_count, 32'd2);
`endif

    for (int i = 0; i < 600; i++) begin
      logic [25:0] a;
      logic        c, w, o, r;
      a = 26'h100 + 26'($urandom_range(0, 63));
      c = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 2) == 0);
      o = ($urandom_range(0, 1) == 0);
      r = ($urandom_range(0, 59) != 0);
      do_op(c, w, o, r, a, $urandom | 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
